// File: rtl/operand_fetch_norm_if.sv
// Operand-fetch bus: start request, input-RAM read port and the operand
// bundle handshake toward the multiply/shift-result stage.
// master = operand_fetch_norm, slave = environment (RAM + downstream).
interface operand_fetch_norm_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int KEEP_W = 8
);
  localparam int SH_W = $clog2(DATA_W - KEEP_W + 1);

  logic              start;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic              op_valid;
  logic              op_ready;
  logic [KEEP_W-1:0] op_a;
  logic [KEEP_W-1:0] op_b;
  logic [SH_W-1:0]   sh_a;
  logic [SH_W-1:0]   sh_b;
  logic              last;
  logic              done;

  modport master (
    input  start, ram_dout, op_ready,
    output ram_rd, ram_addr, op_valid, op_a, op_b, sh_a, sh_b, last, done
  );

  modport slave (
    output start, ram_dout, op_ready,
    input  ram_rd, ram_addr, op_valid, op_a, op_b, sh_a, sh_b, last, done
  );
endinterface

// File: rtl/operand_fetch_norm.sv
// Operand fetch and normalisation stage for the approximate-multiply pipeline.
// Reads PAIRS operand pairs (A at 2i, B at 2i+1), right-shifts each operand
// until it fits in KEEP_W bits, and offers {op_a, op_b, sh_a, sh_b} downstream.
// Optional feature macro: ROUND_EN (round-half-up on the last shifted-out bit,
// saturating at all-ones; without it operands are truncated).
module operand_fetch_norm #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int KEEP_W = 8,
  parameter int PAIRS  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  operand_fetch_norm_if.master     bus
);
  localparam int SH_W = $clog2(DATA_W - KEEP_W + 1);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP_B, NORM, OUT, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-2:0] idx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] a_reg, b_reg;
  logic [SH_W-1:0]   sh_a_q, sh_b_q;
  logic              shift_a, shift_b;
  logic              last_pair;

`ifdef ROUND_EN
  logic              rb_a, rb_b;
  logic [KEEP_W:0]   sum_a, sum_b;
  logic [KEEP_W-1:0] rnd_a, rnd_b;

  // Rounded, saturated KEEP_W-bit results applied when normalisation ends
  always_comb begin
    sum_a = {1'b0, a_reg[KEEP_W-1:0]} + (KEEP_W+1)'(rb_a);
    sum_b = {1'b0, b_reg[KEEP_W-1:0]} + (KEEP_W+1)'(rb_b);
    rnd_a = sum_a[KEEP_W] ? '1 : sum_a[KEEP_W-1:0];
    rnd_b = sum_b[KEEP_W] ? '1 : sum_b[KEEP_W-1:0];
  end
`endif

  // Shift decisions and pair bookkeeping
  always_comb begin
    shift_a   = (state == NORM) && (|a_reg[DATA_W-1:KEEP_W]);
    shift_b   = (state == NORM) && (|b_reg[DATA_W-1:KEEP_W]);
    last_pair = (idx == (ADDR_W-1)'(PAIRS - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = RD_A;
      RD_A:    state_nx = RD_B;
      RD_B:    state_nx = CAP_B;
      CAP_B:   state_nx = NORM;
      NORM:    if (!(shift_a || shift_b)) state_nx = OUT;
      OUT:     if (bus.op_ready) state_nx = last_pair ? DONE : RD_A;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs; address holds its last read value outside RD_A/RD_B
  always_comb begin
    bus.ram_rd   = (state == RD_A) || (state == RD_B);
    bus.ram_addr = addr_q;
    if (state == RD_A) bus.ram_addr = {idx, 1'b0};
    if (state == RD_B) bus.ram_addr = {idx, 1'b1};
    bus.op_valid = (state == OUT);
    bus.last     = (state == OUT) && last_pair;
    bus.done     = (state == DONE);
    bus.op_a     = a_reg[KEEP_W-1:0];
    bus.op_b     = b_reg[KEEP_W-1:0];
    bus.sh_a     = sh_a_q;
    bus.sh_b     = sh_b_q;
  end

  // Datapath: address hold, operand capture, normalisation, pair index
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      addr_q <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      sh_a_q <= '0;
      sh_b_q <= '0;
`ifdef ROUND_EN
      rb_a   <= 1'b0;
      rb_b   <= 1'b0;
`endif
    end else begin
      unique case (state)
        RD_A: addr_q <= {idx, 1'b0};
        RD_B: begin
          addr_q <= {idx, 1'b1};
          a_reg  <= bus.ram_dout;
          sh_a_q <= '0;
`ifdef ROUND_EN
          rb_a   <= 1'b0;
`endif
        end
        CAP_B: begin
          b_reg  <= bus.ram_dout;
          sh_b_q <= '0;
`ifdef ROUND_EN
          rb_b   <= 1'b0;
`endif
        end
        NORM: begin
          if (shift_a) begin
            a_reg  <= a_reg >> 1;
            sh_a_q <= sh_a_q + 1'b1;
`ifdef ROUND_EN
            rb_a   <= a_reg[0];
`endif
          end
          if (shift_b) begin
            b_reg  <= b_reg >> 1;
            sh_b_q <= sh_b_q + 1'b1;
`ifdef ROUND_EN
            rb_b   <= b_reg[0];
`endif
          end
`ifdef ROUND_EN
          // Final NORM cycle (nothing shifts) doubles as the rounding step
          if (!shift_a && !shift_b) begin
            a_reg <= DATA_W'(rnd_a);
            b_reg <= DATA_W'(rnd_b);
          end
`endif
        end
        OUT:  if (bus.op_ready && !last_pair) idx <= idx + 1'b1;
        DONE: idx <= '0;
        default: ;
      endcase
    end
  end
endmodule
